// File: rtl/blinky_pwm_reg.sv
// rtl/blinky_pwm_reg.sv - AXI-Lite register block driving NUM_CH PWM LED channels
// Each channel has its own period/duty; CTRL gates the channels.
module blinky_pwm_reg #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int NUM_CH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [NUM_CH-1:0] led,
  input  logic [7:0]        s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [7:0]        s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready
);

  localparam logic [31:0] VERSION    = 32'd2;
  localparam logic [31:0] RST_PERIOD = 32'(CLK_FREQ);
  localparam logic [31:0] RST_DUTY   = 32'(CLK_FREQ / 2);
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_SLV   = 2'b10;
  localparam logic [1:0]  RESP_DEC   = 2'b11;

  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] led_q, led_d;
  logic [31:0]       period_q [NUM_CH];
  logic [31:0]       period_d [NUM_CH];
  logic [31:0]       duty_q   [NUM_CH];
  logic [31:0]       duty_d   [NUM_CH];
  logic [31:0]       cnt_q    [NUM_CH];
  logic [31:0]       cnt_d    [NUM_CH];

  logic              wr_ready_q, wr_ready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic              wr_fire, rd_fire;
  logic              wr_ctrl, wr_ro;
  logic [NUM_CH-1:0] wr_per, wr_dut;
  logic              wr_rw;
  logic [31:0]       ctrl_merged;
  logic [31:0]       rd_data_c;
  logic [1:0]        rd_resp_c;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  assign wr_fire = wr_ready_q && s_axil_awvalid && s_axil_wvalid;
  assign rd_fire = arready_q && s_axil_arvalid;

  always_comb begin
    wr_ctrl = (s_axil_awaddr == 8'h00);
    wr_ro   = (s_axil_awaddr >= 8'h01) && (s_axil_awaddr <= 8'h03);
    wr_per  = '0;
    wr_dut  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (s_axil_awaddr == 8'(8'h10 + n)) wr_per[n] = 1'b1;
      if (s_axil_awaddr == 8'(8'h20 + n)) wr_dut[n] = 1'b1;
    end
    wr_rw = wr_ctrl || (|wr_per) || (|wr_dut);
  end

  // Read mux sees only the current state, so a same-cycle write is not visible.
  always_comb begin
    rd_data_c = 32'd0;
    rd_resp_c = RESP_DEC;
    case (s_axil_araddr)
      8'h00: begin rd_data_c = 32'(en_q);   rd_resp_c = RESP_OKAY; end
      8'h01: begin rd_data_c = VERSION;     rd_resp_c = RESP_OKAY; end
      8'h02: begin rd_data_c = RST_PERIOD;  rd_resp_c = RESP_OKAY; end
      8'h03: begin rd_data_c = 32'(NUM_CH); rd_resp_c = RESP_OKAY; end
      default: begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (s_axil_araddr == 8'(8'h10 + n)) begin
            rd_data_c = period_q[n];
            rd_resp_c = RESP_OKAY;
          end
          if (s_axil_araddr == 8'(8'h20 + n)) begin
            rd_data_c = duty_q[n];
            rd_resp_c = RESP_OKAY;
          end
        end
      end
    endcase
  end

  always_comb begin
    ctrl_merged = strb_merge(32'(en_q), s_axil_wdata, s_axil_wstrb);
    en_d = en_q;
    if (wr_fire && wr_ctrl) en_d = ctrl_merged[NUM_CH-1:0];

    for (int n = 0; n < NUM_CH; n++) begin
      period_d[n] = period_q[n];
      duty_d[n]   = duty_q[n];
      if (wr_fire && wr_per[n])
        period_d[n] = strb_merge(period_q[n], s_axil_wdata, s_axil_wstrb);
      if (wr_fire && wr_dut[n])
        duty_d[n] = strb_merge(duty_q[n], s_axil_wdata, s_axil_wstrb);

      // Wrap on >= rather than == so the counter can never run past the period.
      if (!en_q[n] || (en_d[n] && !en_q[n]) || (wr_fire && wr_per[n]) ||
          (period_q[n] <= 32'd1))
        cnt_d[n] = 32'd0;
      else if (cnt_q[n] >= period_q[n] - 32'd1)
        cnt_d[n] = 32'd0;
      else
        cnt_d[n] = cnt_q[n] + 32'd1;

      if (period_q[n] <= 32'd1)
        led_d[n] = en_q[n] && (duty_q[n] != 32'd0);
      else
        led_d[n] = en_q[n] && (cnt_q[n] < duty_q[n]);
    end
  end

  always_comb begin
    wr_ready_d = s_axil_awvalid && s_axil_wvalid && !bvalid_q && !wr_ready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    if (bvalid_q && s_axil_bready) bvalid_d = 1'b0;
    if (wr_fire) begin
      bvalid_d = 1'b1;
      if (wr_rw)      bresp_d = RESP_OKAY;
      else if (wr_ro) bresp_d = RESP_SLV;
      else            bresp_d = RESP_DEC;
    end

    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_axil_rready) rvalid_d = 1'b0;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data_c;
      rresp_d  = rd_resp_c;
    end
    arready_d = !rvalid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q       <= '0;
      led_q      <= '0;
      wr_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
      rresp_q    <= RESP_OKAY;
      for (int n = 0; n < NUM_CH; n++) begin
        period_q[n] <= RST_PERIOD;
        duty_q[n]   <= RST_DUTY;
        cnt_q[n]    <= 32'd0;
      end
    end else begin
      en_q       <= en_d;
      led_q      <= led_d;
      wr_ready_q <= wr_ready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      for (int n = 0; n < NUM_CH; n++) begin
        period_q[n] <= period_d[n];
        duty_q[n]   <= duty_d[n];
        cnt_q[n]    <= cnt_d[n];
      end
    end
  end

  assign led            = led_q;
  assign s_axil_awready = wr_ready_q;
  assign s_axil_wready  = wr_ready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

endmodule

// File: tb/tb_blinky_pwm_reg.sv
// tb/tb_blinky_pwm_reg.sv - scoreboard bench for blinky_pwm_reg
module tb_blinky_pwm_reg;
  localparam int CLK_FREQ = 100_000_000;
  localparam int NUM_CH   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] led;
  logic [7:0]        awaddr = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b1;
  logic [7:0]        araddr = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready = 1'b1;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  logic [1:0]  b_exp;
  logic [33:0] r_exp;

  always #5 clk = ~clk;

  blinky_pwm_reg #(.CLK_FREQ(CLK_FREQ), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .led(led),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
    .s_axil_wready(wready), .s_axil_bresp(bresp), .s_axil_bvalid(bvalid),
    .s_axil_bready(bready), .s_axil_araddr(araddr), .s_axil_arvalid(arvalid),
    .s_axil_arready(arready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (bq.size() == 0) chk("b_unexpected", 32'(bvalid), 32'd0);
      else begin
        b_exp = bq.pop_front();
        chk("bresp", 32'(bresp), 32'(b_exp));
      end
    end
    if (rst_n && rvalid && rready) begin
      if (rq.size() == 0) chk("r_unexpected", 32'(rvalid), 32'd0);
      else begin
        r_exp = rq.pop_front();
        chk("rdata", rdata, r_exp[31:0]);
        chk("rresp", 32'(rresp), 32'(r_exp[33:32]));
      end
    end
  end

  task automatic wait_aw();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready) break;
    end
    if (!awready) chk("aw_timeout", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic wait_b();
    for (int i = 0; i < 50; i++) begin
      if (bq.size() == 0) break;
      @(negedge clk);
    end
    if (bq.size() != 0) begin
      chk("b_timeout", 32'(bq.size()), 32'd0);
      bq.delete();
    end
  endtask

  task automatic wait_r();
    for (int i = 0; i < 50; i++) begin
      if (rq.size() == 0) break;
      @(negedge clk);
    end
    if (rq.size() != 0) begin
      chk("r_timeout", 32'(rq.size()), 32'd0);
      rq.delete();
    end
  endtask

  task automatic wr_issue(input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] e);
    bq.push_back(e);
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    wait_aw();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] e);
    wr_issue(a, d, s, e);
    wait_b();
  endtask

  task automatic rd_issue(input logic [7:0] a, input logic [31:0] d, input logic [1:0] e);
    rq.push_back({e, d});
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) break;
    end
    if (!arready) chk("ar_timeout", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] d, input logic [1:0] e);
    rd_issue(a, d, e);
    wait_r();
  endtask

  task automatic hold_led(input string tag, input int ch, input logic exp, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk(tag, 32'(led[ch]), 32'(exp));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    rd(8'h00, 32'd0, 2'b00);
    rd(8'h01, 32'd2, 2'b00);
    rd(8'h02, 32'(CLK_FREQ), 2'b00);
    rd(8'h03, 32'd4, 2'b00);
    rd(8'h10, 32'(CLK_FREQ), 2'b00);
    rd(8'h20, 32'(CLK_FREQ / 2), 2'b00);

    // ch1: 3 high, 7 low; align on a rising edge then check 3 periods
    wr(8'h11, 32'd10, 4'hF, 2'b00);
    wr(8'h21, 32'd3, 4'hF, 2'b00);
    wr(8'h00, 32'h2, 4'hF, 2'b00);
    for (int i = 0; i < 20; i++) begin
      if (!led[1]) break;
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      if (led[1]) break;
      @(negedge clk);
    end
    chk("pwm1_start", 32'(led[1]), 32'd1);
    for (int i = 0; i < 30; i++) begin
      chk("pwm1", 32'(led), ((i % 10) < 3) ? 32'h2 : 32'h0);
      @(negedge clk);
    end

    wr(8'h12, 32'd10, 4'hF, 2'b00);
    wr(8'h22, 32'd0, 4'hF, 2'b00);
    wr(8'h00, 32'h6, 4'hF, 2'b00);
    repeat (3) @(negedge clk);
    hold_led("duty0", 2, 1'b0, 20);
    wr(8'h22, 32'd20, 4'hF, 2'b00);
    repeat (3) @(negedge clk);
    hold_led("duty_gt_period", 2, 1'b1, 20);
    wr(8'h12, 32'd0, 4'hF, 2'b00);
    wr(8'h22, 32'd1, 4'hF, 2'b00);
    repeat (3) @(negedge clk);
    hold_led("period0", 2, 1'b1, 20);
    wr(8'h00, 32'h2, 4'hF, 2'b00);
    @(negedge clk);
    hold_led("disable", 2, 1'b0, 5);

    wr(8'h02, 32'h1234, 4'hF, 2'b10);
    rd(8'h02, 32'(CLK_FREQ), 2'b00);
    wr(8'h40, 32'h1, 4'hF, 2'b11);
    rd(8'h40, 32'd0, 2'b11);
    wr(8'h24, 32'h1, 4'hF, 2'b11);

    wr(8'h10, 32'hFFFF_FFFF, 4'h1, 2'b00);
    rd(8'h10, 32'h05F5_E1FF, 2'b00);
    wr(8'h20, 32'd0, 4'h0, 2'b00);
    rd(8'h20, 32'(CLK_FREQ / 2), 2'b00);

    // write response held off: second write must wait
    @(posedge clk); #1;
    bready = 1'b0;
    wr_issue(8'h13, 32'd7, 4'hF, 2'b00);
    bq.push_back(2'b00);
    @(posedge clk); #1;
    awaddr = 8'h23; wdata = 32'd5; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_bvalid", 32'(bvalid), 32'd1);
      chk("bp_awready", 32'(awready), 32'd0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    wait_aw();
    wait_b();
    rd(8'h13, 32'd7, 2'b00);
    rd(8'h23, 32'd5, 2'b00);

    // same-cycle read and write of CTRL
    bq.push_back(2'b00);
    rq.push_back({2'b00, 32'h2});
    @(posedge clk); #1;
    awaddr = 8'h00; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    araddr = 8'h00; arvalid = 1'b1;
    @(negedge clk);
    chk("same_awready", 32'(awready), 32'd1);
    chk("same_arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wait_b();
    wait_r();
    rd(8'h00, 32'hF, 2'b00);

    // reset while a read response is pending
    @(posedge clk); #1;
    rready = 1'b0;
    rd_issue(8'h01, 32'd2, 2'b00);
    @(negedge clk);
    chk("pend_rvalid", 32'(rvalid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    rq.delete();
    bq.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_rvalid", 32'(rvalid), 32'd0);
      chk("post_rst_bvalid", 32'(bvalid), 32'd0);
    end
    chk("post_rst_led", 32'(led), 32'd0);
    rd(8'h00, 32'd0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
